// File: rtl/rx_dma_chan_run_ctrl.sv
// Per-channel start/stop controller for the RX DMA datapath.
// Turns software start/stop pulses into a per-channel ACTIVE mask, tracks
// packets in flight per channel, and acknowledges a stop once the channel has
// drained or its drain timer expires.
module rx_dma_chan_run_ctrl #(
  parameter int unsigned CHANNELS       = 8,
  parameter int unsigned INFLIGHT_WIDTH = 8,
  parameter int unsigned TIMEOUT_WIDTH  = 16,
  parameter int unsigned STOP_TIMEOUT   = 4096,
  localparam int unsigned CHAN_W        = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   start_req,
  input  logic [CHANNELS-1:0]   stop_req,
  input  logic                  pkt_sof_vld,
  input  logic [CHAN_W-1:0]     pkt_sof_chan,
  input  logic                  pkt_done_vld,
  input  logic [CHAN_W-1:0]     pkt_done_chan,
  output logic [CHANNELS-1:0]   chan_active,
  output logic [2*CHANNELS-1:0] chan_state,
  output logic [CHANNELS-1:0]   stop_done,
  output logic [CHANNELS-1:0]   timeout_err,
  output logic                  err_underflow,
  output logic                  err_overflow
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STOPPING = 2'b10
  } state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(STOP_TIMEOUT - 1);
  localparam logic [INFLIGHT_WIDTH-1:0] CNT_MAX   = '1;

  state_e                    state_q [CHANNELS];
  logic [INFLIGHT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [INFLIGHT_WIDTH-1:0] cnt_nxt [CHANNELS];
  logic [TIMEOUT_WIDTH-1:0]  timer_q [CHANNELS];
  logic [CHANNELS-1:0]       inc_c;
  logic [CHANNELS-1:0]       dec_c;
  logic [CHANNELS-1:0]       ovf_c;
  logic [CHANNELS-1:0]       unf_c;

  // In-flight counter next value and saturation/underflow detection per channel
  always_comb begin
    inc_c = '0;
    dec_c = '0;
    ovf_c = '0;
    unf_c = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cnt_nxt[ch] = cnt_q[ch];
      inc_c[ch]   = pkt_sof_vld && (pkt_sof_chan == CHAN_W'(ch)) && chan_active[ch];
      dec_c[ch]   = pkt_done_vld && (pkt_done_chan == CHAN_W'(ch));
      if (inc_c[ch] && !dec_c[ch]) begin
        if (cnt_q[ch] == CNT_MAX) ovf_c[ch] = 1'b1;
        else                      cnt_nxt[ch] = cnt_q[ch] + INFLIGHT_WIDTH'(1);
      end else if (dec_c[ch] && !inc_c[ch]) begin
        if (cnt_q[ch] == '0) unf_c[ch] = 1'b1;
        else                 cnt_nxt[ch] = cnt_q[ch] - INFLIGHT_WIDTH'(1);
      end
    end
  end

  // Per-channel run FSMs, counters, drain timers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= ST_STOPPED;
        cnt_q[ch]   <= '0;
        timer_q[ch] <= '0;
      end
      chan_active   <= '0;
      stop_done     <= '0;
      timeout_err   <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      stop_done     <= '0;
      err_underflow <= |unf_c;
      err_overflow  <= |ovf_c;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= cnt_nxt[ch];
        case (state_q[ch])
          ST_STOPPED: begin
            if (start_req[ch]) begin
              state_q[ch]     <= ST_RUNNING;
              chan_active[ch] <= 1'b1;
              timeout_err[ch] <= 1'b0;
            end
          end
          ST_RUNNING: begin
            // Stop wins over a simultaneous start
            if (stop_req[ch]) begin
              state_q[ch]     <= ST_STOPPING;
              chan_active[ch] <= 1'b0;
              timer_q[ch]     <= '0;
            end
          end
          ST_STOPPING: begin
            timer_q[ch] <= timer_q[ch] + TIMEOUT_WIDTH'(1);
            if (cnt_nxt[ch] == '0) begin
              state_q[ch]   <= ST_STOPPED;
              stop_done[ch] <= 1'b1;
            end else if (timer_q[ch] == TIMER_LAST) begin
              // Forced stop: packets still in flight are abandoned
              state_q[ch]     <= ST_STOPPED;
              stop_done[ch]   <= 1'b1;
              cnt_q[ch]       <= '0;
              timeout_err[ch] <= 1'b1;
            end
          end
          default: begin
            state_q[ch]     <= ST_STOPPED;
            chan_active[ch] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pack per-channel state registers onto the status bus
  always_comb begin
    chan_state = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      chan_state[2*ch +: 2] = state_q[ch];
    end
  end

endmodule

// File: tb/tb_rx_dma_chan_run_ctrl.sv
// Directed self-checking bench for rx_dma_chan_run_ctrl.
// Small inflight counter and short drain timeout so saturation and forced
// stop are reachable in a few cycles.
module tb_rx_dma_chan_run_ctrl;

  localparam int unsigned CHANNELS = 8;
  localparam int unsigned CHAN_W   = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CHANNELS-1:0]   start_req;
  logic [CHANNELS-1:0]   stop_req;
  logic                  pkt_sof_vld;
  logic [CHAN_W-1:0]     pkt_sof_chan;
  logic                  pkt_done_vld;
  logic [CHAN_W-1:0]     pkt_done_chan;
  logic [CHANNELS-1:0]   chan_active;
  logic [2*CHANNELS-1:0] chan_state;
  logic [CHANNELS-1:0]   stop_done;
  logic [CHANNELS-1:0]   timeout_err;
  logic                  err_underflow;
  logic                  err_overflow;

  int checks = 0;
  int errors = 0;

  rx_dma_chan_run_ctrl #(
    .CHANNELS       (CHANNELS),
    .INFLIGHT_WIDTH (2),
    .TIMEOUT_WIDTH  (16),
    .STOP_TIMEOUT   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .pkt_sof_vld   (pkt_sof_vld),
    .pkt_sof_chan  (pkt_sof_chan),
    .pkt_done_vld  (pkt_done_vld),
    .pkt_done_chan (pkt_done_chan),
    .chan_active   (chan_active),
    .chan_state    (chan_state),
    .stop_done     (stop_done),
    .timeout_err   (timeout_err),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start_req    = '0;
    stop_req     = '0;
    pkt_sof_vld  = 1'b0;
    pkt_done_vld = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 32'(chan_active), 32'h0);
    check({tag, "_state"},  32'(chan_state),  32'h0);
    check({tag, "_sdone"},  32'(stop_done),   32'h0);
    check({tag, "_toerr"},  32'(timeout_err), 32'h0);
    check({tag, "_unf"},    32'(err_underflow), 32'h0);
    check({tag, "_ovf"},    32'(err_overflow),  32'h0);
  endtask

  initial begin
    reset         = 1'b0;
    pkt_sof_chan  = '0;
    pkt_done_chan = '0;
    idle();
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    repeat (6) tick();

    // Start ch3
    start_req = 8'h08;
    tick();
    idle();
    check("start3_active", 32'(chan_active), 32'h08);
    check("start3_state",  32'(chan_state),  32'h0040);

    // Three packets on ch3, then stop; drain with DONEs five cycles apart
    pkt_sof_vld = 1'b1; pkt_sof_chan = 3'd3;
    repeat (3) tick();
    idle();
    stop_req = 8'h08;
    tick();
    idle();
    check("stop3_active", 32'(chan_active), 32'h00);
    check("stop3_state",  32'(chan_state),  32'h0080);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        repeat (4) tick();
        check("drain3_sdone_gap", 32'(stop_done), 32'h0);
      end
      pkt_done_vld = 1'b1; pkt_done_chan = 3'd3;
      tick();
      idle();
      if (i < 2) check("drain3_state_mid", 32'(chan_state), 32'h0080);
    end
    check("drain3_sdone", 32'(stop_done),   32'h08);
    check("drain3_state", 32'(chan_state),  32'h0000);
    check("drain3_toerr", 32'(timeout_err), 32'h00);
    check("drain3_unf",   32'(err_underflow), 32'h0);
    tick();
    check("drain3_sdone_pulse", 32'(stop_done), 32'h00);

    // Ch1: two packets in flight, stop without DONEs -> forced stop after 16 cycles
    start_req = 8'h02;
    tick();
    idle();
    pkt_sof_vld = 1'b1; pkt_sof_chan = 3'd1;
    repeat (2) tick();
    idle();
    stop_req = 8'h02;
    tick();
    idle();
    repeat (15) tick();
    check("to1_state_15", 32'(chan_state), 32'h0008);
    check("to1_sdone_15", 32'(stop_done),  32'h00);
    tick();
    check("to1_state",  32'(chan_state),  32'h0000);
    check("to1_sdone",  32'(stop_done),   32'h02);
    check("to1_toerr",  32'(timeout_err), 32'h02);
    tick();
    check("to1_sdone_pulse", 32'(stop_done),   32'h00);
    check("to1_toerr_hold",  32'(timeout_err), 32'h02);
    pkt_done_vld = 1'b1; pkt_done_chan = 3'd1;
    tick();
    idle();
    check("to1_late_unf", 32'(err_underflow), 32'h1);
    tick();
    check("to1_late_unf_pulse", 32'(err_underflow), 32'h0);
    start_req = 8'h02;
    tick();
    idle();
    check("to1_restart_toerr",  32'(timeout_err), 32'h00);
    check("to1_restart_active", 32'(chan_active), 32'h02);

    // Stop ch1 with an empty counter: STOP_DONE two cycles after the request
    stop_req = 8'h02;
    tick();
    idle();
    check("empty1_state", 32'(chan_state), 32'h0008);
    tick();
    check("empty1_sdone", 32'(stop_done),  32'h02);
    check("empty1_state_done", 32'(chan_state), 32'h0000);

    // Ch0: counter=1, then 20 cycles of simultaneous SOF+DONE
    start_req = 8'h01;
    tick();
    idle();
    pkt_sof_vld = 1'b1; pkt_sof_chan = 3'd0;
    tick();
    pkt_done_vld = 1'b1; pkt_done_chan = 3'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("both0_errs", 32'({err_overflow, err_underflow}), 32'h0);
    end
    idle();
    start_req = 8'h01;
    stop_req  = 8'h01;
    tick();
    idle();
    check("both0_stopwins_state",  32'(chan_state),  32'h0002);
    check("both0_stopwins_active", 32'(chan_active), 32'h00);
    tick();
    check("both0_still_stopping", 32'(chan_state), 32'h0002);
    pkt_done_vld = 1'b1; pkt_done_chan = 3'd0;
    tick();
    idle();
    check("both0_sdone", 32'(stop_done),     32'h01);
    check("both0_state", 32'(chan_state),    32'h0000);
    check("both0_unf",   32'(err_underflow), 32'h0);

    // Ch2: saturate 2-bit counter
    start_req = 8'h04;
    tick();
    idle();
    pkt_sof_vld = 1'b1; pkt_sof_chan = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf2_no_err", 32'(err_overflow), 32'h0);
    end
    tick();
    idle();
    check("ovf2_err", 32'(err_overflow), 32'h1);
    tick();
    check("ovf2_err_pulse", 32'(err_overflow), 32'h0);
    stop_req = 8'h04;
    tick();
    idle();
    pkt_done_vld = 1'b1; pkt_done_chan = 3'd2;
    repeat (2) tick();
    check("ovf2_state_mid", 32'(chan_state), 32'h0020);
    tick();
    idle();
    check("ovf2_sdone", 32'(stop_done),     32'h04);
    check("ovf2_unf",   32'(err_underflow), 32'h0);

    // SOF on an inactive channel is ignored silently
    pkt_sof_vld = 1'b1; pkt_sof_chan = 3'd6;
    tick();
    idle();
    tick();
    check("inactive_sof_ovf", 32'(err_overflow), 32'h0);

    // Ch5 stopping with one packet in flight, then asynchronous reset
    start_req = 8'h20;
    tick();
    idle();
    check("r5_state_run", 32'(chan_state), 32'h0400);
    pkt_sof_vld = 1'b1; pkt_sof_chan = 3'd5;
    tick();
    idle();
    stop_req = 8'h20;
    tick();
    idle();
    check("r5_state_stopping", 32'(chan_state), 32'h0800);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("r5_async");
    tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("r5_no_sdone", 32'(stop_done), 32'h00);
    end
    check("r5_state_after", 32'(chan_state), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_dma_chan_run_ctrl.md
Name: rx_dma_chan_run_ctrl

Overview:
Per-channel start/stop controller for the RX DMA (Calypte) datapath. It converts software start/stop requests into a per-channel ACTIVE mask for the header manager. It counts packets in flight between header dispatch and PCIe-up write completion. A stop is acknowledged only after the channel has drained, or after a timeout expires.

Parameters:
CHANNELS, 8, number of DMA channels (power of 2, >=2)
INFLIGHT_WIDTH, 8, width of the per-channel in-flight packet counter
TIMEOUT_WIDTH, 16, width of the per-channel drain timer
STOP_TIMEOUT, 4096, cycles allowed in STOPPING before a forced stop (1..2^TIMEOUT_WIDTH-1)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous reset, active-low
START_REQ  in  CHANNELS  one-cycle start pulse per channel (from MI register block)
STOP_REQ  in  CHANNELS  one-cycle stop pulse per channel
PKT_SOF_VLD  in  1  header accepted into the datapath this cycle
PKT_SOF_CHAN  in  log2(CHANNELS)  channel of the accepted header
PKT_DONE_VLD  in  1  last PCIe-up write of a packet left the block
PKT_DONE_CHAN  in  log2(CHANNELS)  channel of the completed packet
CHAN_ACTIVE  out  CHANNELS  1 = channel accepts new packets (others are discarded upstream)
CHAN_STATE  out  2*CHANNELS  per-channel state: 00 STOPPED, 01 RUNNING, 10 STOPPING
STOP_DONE  out  CHANNELS  one-cycle pulse when a channel enters STOPPED from STOPPING
TIMEOUT_ERR  out  CHANNELS  sticky: last stop was forced by the timeout
ERR_UNDERFLOW  out  1  one-cycle pulse: DONE received on a channel with counter 0
ERR_OVERFLOW  out  1  one-cycle pulse: SOF received on a channel with a saturated counter

Behaviour:
- Reset (RESET=0, asynchronous):
  - All channels STOPPED; counters and timers are 0.
  - All outputs are 0.
- Each channel has its own independent FSM. All outputs are registered.
- STOPPED:
  - START_REQ -> RUNNING. TIMEOUT_ERR[ch] is cleared in the same transition.
  - STOP_REQ is ignored.
- RUNNING:
  - STOP_REQ -> STOPPING.
  - START_REQ is ignored.
  - If START_REQ and STOP_REQ arrive in the same cycle, STOP wins.
- STOPPING:
  - START_REQ and STOP_REQ are ignored.
  - The timer increments every cycle.
  - Counter==0 (after this cycle's update) -> STOPPED, with a STOP_DONE pulse.
  - Otherwise, timer==STOP_TIMEOUT-1 -> STOPPED, STOP_DONE pulse, counter forced to 0, TIMEOUT_ERR[ch] set.
  - The timer resets to 0 on entry to STOPPING.
- Timing:
  - CHAN_ACTIVE[ch] = (state==RUNNING). It rises and falls one cycle after the request pulse.
  - STOP_DONE is issued one cycle after the counter reaches 0. If the counter is already 0 when STOP_REQ arrives, STOPPING lasts exactly 1 cycle: STOP_DONE is high 2 cycles after STOP_REQ.
- Counter update per cycle, for each channel:
  - inc = PKT_SOF_VLD and PKT_SOF_CHAN==ch and CHAN_ACTIVE[ch]==1 (the registered value in that cycle).
  - dec = PKT_DONE_VLD and PKT_DONE_CHAN==ch.
  - inc and dec together -> counter unchanged, no error.
  - inc alone at all-ones -> counter holds at saturation, ERR_OVERFLOW pulses.
  - dec alone at 0 -> counter stays 0, ERR_UNDERFLOW pulses.
  - SOF on an inactive channel has no effect and raises no error.
- Packets that complete after a forced stop: their DONE events hit a zero counter and raise ERR_UNDERFLOW. This is intended and reported.
- Multiple channels may change state or pulse STOP_DONE in the same cycle. The channel FSMs do not interact.
- Reset asserted mid-operation: immediate return to the reset state. Pending stops are not acknowledged.

Test Plan:
- Reset, START_REQ[3] pulse at cycle 10 -> CHAN_ACTIVE[3]=1 and CHAN_STATE[7:6]=01 from cycle 11; all other channels remain 00.
- Ch3 RUNNING, 3 SOFs on ch3, then STOP_REQ[3] -> CHAN_ACTIVE[3]=0 next cycle. 3 DONEs on ch3 spaced 5 cycles apart -> STOP_DONE[3] single pulse 1 cycle after the 3rd DONE; state returns to 00; TIMEOUT_ERR[3]=0.
- STOP_TIMEOUT=16, ch1 with 2 packets in flight, STOP_REQ[1], no DONEs -> STOPPED and STOP_DONE[1] after 16 cycles in STOPPING; TIMEOUT_ERR[1]=1. A later DONE on ch1 -> ERR_UNDERFLOW pulse. START_REQ[1] -> TIMEOUT_ERR[1] cleared.
- Simultaneous SOF and DONE on ch0 with counter=1 for 20 cycles -> counter remains 1, no error pulses. START_REQ[0] and STOP_REQ[0] together while RUNNING -> STOPPING.
- INFLIGHT_WIDTH=2, 4 SOFs on ch2 with no DONEs -> ERR_OVERFLOW pulses on the 4th SOF; counter stays at 3.
- Ch5 in STOPPING with 1 packet in flight, RESET pulled low -> all outputs 0 immediately (asynchronously), no STOP_DONE pulse.
